iw_move_unit: RTL

//   Parametrised, multi-cycle successor to the wide-immediate (IW) decode path. Accepts MOVZ/MOVN/MOVK words
//   via valid/ready. Sequences the control word and K constant driving the ALU / register-file / PC datapath.

---
 rtl/iw_pkg.sv | 41 ++++
 rtl/iw_k_gen.sv | 33 +++
 rtl/iw_move_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/iw_pkg.sv
// Shared constants for the wide-immediate move unit: opcodes, ALU/PC function
// codes, FSM state encoding and control-word field offsets.
package iw_pkg;

  localparam logic [8:0] OP_MOVZ = 9'h1A5;
  localparam logic [8:0] OP_MOVK = 9'h1E5;
  localparam logic [8:0] OP_MOVN = 9'h125;

  localparam logic [4:0] ALU_PASS_B = 5'b01100;
  localparam logic [4:0] ALU_AND    = 5'b01000;
  localparam logic [4:0] ALU_ORR    = 5'b01010;

  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC1 = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  // Bit offsets (LSB of each field) within the 33-bit control word.
  localparam int CW_BITS       = 33;
  localparam int CW_NEXT_STATE = 0;
  localparam int CW_STATUS_LD  = 2;
  localparam int CW_PC_IN_SEL  = 3;
  localparam int CW_PC_FS      = 4;
  localparam int CW_PC_DB_EN   = 6;
  localparam int CW_RAM_W      = 7;
  localparam int CW_RAM_DB_EN  = 8;
  localparam int CW_RF_W       = 9;
  localparam int CW_WA         = 10;
  localparam int CW_SB         = 15;
  localparam int CW_SA         = 20;
  localparam int CW_RF_B_DB_EN = 25;
  localparam int CW_ALU_FS     = 26;
  localparam int CW_ALU_B_SEL  = 31;
  localparam int CW_ALU_DB_EN  = 32;

endpackage

// File: rtl/iw_k_gen.sv
// Immediate shaper: places the move granule at hw*HW_W and builds the matching
// field mask; flags granule indices that fall outside the datapath.
module iw_k_gen
  import iw_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int HW_W   = 16
) (
  input  logic [HW_W-1:0]   imm_i,
  input  logic [1:0]        hw_i,
  output logic [DATA_W-1:0] sh_imm_o,
  output logic [DATA_W-1:0] mask_o,
  output logic              hw_ok_o
);

  localparam int unsigned NUM_HW = DATA_W / HW_W;

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] ones_ext;
  int unsigned       shift;

  always_comb begin
    imm_ext               = '0;
    imm_ext[HW_W-1:0]     = imm_i;
    ones_ext              = '0;
    ones_ext[HW_W-1:0]    = '1;
    shift                 = 32'(hw_i) * 32'(HW_W);
    sh_imm_o              = imm_ext << shift;
    mask_o                = ones_ext << shift;
    hw_ok_o               = 32'(hw_i) < NUM_HW;
  end

endmodule

// File: rtl/iw_move_unit.sv
// MOVZ/MOVN/MOVK sequencer: latches one move instruction and emits the per-cycle
// control word and K constant; MOVK runs as AND ~mask followed by ORR sh_imm.
module iw_move_unit
  import iw_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int HW_W    = 16,
  parameter int CW_W    = 33,
  parameter int EN_MOVN = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       I,
  output logic [CW_W-1:0]   cw,
  output logic [DATA_W-1:0] K,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  state_e state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] src;
  logic [8:0]  op;
  logic [1:0]  hw;
  logic [4:0]  rd;
  logic [DATA_W-1:0] sh_imm, mask;
  logic        hw_ok, op_ok;
  logic [CW_BITS-1:0] cw_word;

  // In IDLE the legality check looks at the incoming word; afterwards at the latch.
  assign src = (state_q == ST_IDLE) ? I : instr_q;
  assign op  = src[31:23];
  assign hw  = src[22:21];
  assign rd  = src[4:0];
  assign op_ok = (op == OP_MOVZ) || (op == OP_MOVK) || ((op == OP_MOVN) && (EN_MOVN != 0));

  iw_k_gen #(.DATA_W(DATA_W), .HW_W(HW_W)) u_k_gen (
    .imm_i    (src[5 +: HW_W]),
    .hw_i     (hw),
    .sh_imm_o (sh_imm),
    .mask_o   (mask),
    .hw_ok_o  (hw_ok)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && instr_valid) instr_q <= I;
    end
  end

  always_comb begin
    state_d = state_q;
    cw_word = '0;
    K       = '0;
    done    = 1'b0;
    illegal = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) state_d = (op_ok && hw_ok) ? ST_EXEC1 : ST_FAULT;
      end
      ST_EXEC1: begin
        cw_word[CW_ALU_DB_EN]       = 1'b1;
        cw_word[CW_ALU_B_SEL]       = 1'b1;
        cw_word[CW_WA +: 5]         = rd;
        cw_word[CW_RF_W]            = 1'b1;
        if (op == OP_MOVK) begin
          state_d                   = ST_EXEC2;
          K                         = ~mask;
          cw_word[CW_ALU_FS +: 5]   = ALU_AND;
          cw_word[CW_SA +: 5]       = rd;
          cw_word[CW_PC_FS +: 2]    = PC_HOLD;
        end else begin
          state_d                   = ST_IDLE;
          K                         = (op == OP_MOVN) ? ~sh_imm : sh_imm;
          cw_word[CW_ALU_FS +: 5]   = ALU_PASS_B;
          cw_word[CW_PC_FS +: 2]    = PC_INC;
          done                      = 1'b1;
        end
        cw_word[CW_NEXT_STATE +: 2] = state_d;
      end
      ST_EXEC2: begin
        state_d                     = ST_IDLE;
        K                           = sh_imm;
        cw_word[CW_ALU_DB_EN]       = 1'b1;
        cw_word[CW_ALU_B_SEL]       = 1'b1;
        cw_word[CW_ALU_FS +: 5]     = ALU_ORR;
        cw_word[CW_SA +: 5]         = rd;
        cw_word[CW_WA +: 5]         = rd;
        cw_word[CW_RF_W]            = 1'b1;
        cw_word[CW_PC_FS +: 2]      = PC_INC;
        cw_word[CW_NEXT_STATE +: 2] = state_d;
        done                        = 1'b1;
      end
      ST_FAULT: begin
        state_d = ST_IDLE;
        illegal = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cw          = CW_W'(cw_word);
  assign busy        = (state_q != ST_IDLE);
  assign instr_ready = (state_q == ST_IDLE);

endmodule
